dfp_arbiter: RTL and testbench



---
 rtl/dfp_arbiter.sv | 101 ++++++++++
 tb/tb_dfp_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dfp_arbiter.sv
// dfp_arbiter: round-robin share of one cacheline memory port between I-cache (0) and D-cache (1),
// with one-shot affinity so a dirty writeback's refill is granted next.
module dfp_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic              req0_read,
    input  logic              req0_write,
    input  logic [LINE_W-1:0] req0_wdata,
    output logic [LINE_W-1:0] req0_rdata,
    output logic              req0_resp,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic              req1_read,
    input  logic              req1_write,
    input  logic [LINE_W-1:0] req1_wdata,
    output logic [LINE_W-1:0] req1_rdata,
    output logic              req1_resp,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);
    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;
    state_t state, state_n;
    logic last_grant, last_grant_n, aff_valid, aff_valid_n, aff_id, aff_id_n;
    logic op_write, op_write_n, rq0, rq1, grant;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [LINE_W-1:0] wdata_q, wdata_n;

    assign rq0 = req0_read | req0_write;
    assign rq1 = req1_read | req1_write;
    // affinity beats round-robin only when the affinity owner is actually asking
    assign grant = (aff_valid && (aff_id ? rq1 : rq0)) ? aff_id : (rq0 && rq1) ? ~last_grant : rq1;
    assign mem_addr = addr_q;
    assign mem_wdata = wdata_q;
    assign req0_rdata = mem_rdata;
    assign req1_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last_grant <= 1'b1;
            aff_valid <= 1'b0;
            aff_id <= 1'b0;
            op_write <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_n;
            last_grant <= last_grant_n;
            aff_valid <= aff_valid_n;
            aff_id <= aff_id_n;
            op_write <= op_write_n;
            addr_q <= addr_n;
            wdata_q <= wdata_n;
        end
    end

    always_comb begin
        state_n = state;
        last_grant_n = last_grant;
        aff_valid_n = aff_valid;
        aff_id_n = aff_id;
        op_write_n = op_write;
        addr_n = addr_q;
        wdata_n = wdata_q;
        mem_read = 1'b0;
        mem_write = 1'b0;
        req0_resp = 1'b0;
        req1_resp = 1'b0;
        case (state)
            IDLE: begin
                aff_valid_n = 1'b0;
                if (rq0 || rq1) begin
                    state_n = grant ? BUSY1 : BUSY0;
                    last_grant_n = grant;
                    op_write_n = grant ? req1_write : req0_write;
                    addr_n = grant ? req1_addr : req0_addr;
                    wdata_n = grant ? req1_wdata : req0_wdata;
                end
            end
            BUSY0, BUSY1: begin
                mem_read = ~op_write;
                mem_write = op_write;
                req0_resp = mem_resp && state == BUSY0;
                req1_resp = mem_resp && state == BUSY1;
                if (mem_resp) begin
                    state_n = IDLE;
                    aff_valid_n = op_write;
                    aff_id_n = state == BUSY1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dfp_arbiter.sv
// tb_dfp_arbiter: directed scenarios plus randomized traffic against a transaction-level reference model.
module tb_dfp_arbiter;
    localparam int AW = 32;
    localparam int LW = 256;
    logic clk = 1'b0, rst;
    logic [AW-1:0] req0_addr, req1_addr, mem_addr;
    logic req0_read, req0_write, req0_resp, req1_read, req1_write, req1_resp;
    logic [LW-1:0] req0_wdata, req0_rdata, req1_wdata, req1_rdata, mem_wdata, mem_rdata;
    logic mem_read, mem_write, mem_resp;
    int checks = 0, failures = 0;

    dfp_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk(clk), .rst(rst),
        .req0_addr(req0_addr), .req0_read(req0_read), .req0_write(req0_write),
        .req0_wdata(req0_wdata), .req0_rdata(req0_rdata), .req0_resp(req0_resp),
        .req1_addr(req1_addr), .req1_read(req1_read), .req1_write(req1_write),
        .req1_wdata(req1_wdata), .req1_rdata(req1_rdata), .req1_resp(req1_resp),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        req0_read = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0;
        req1_read = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;
        mem_resp = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_all();
        step();
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_all();
        step();
        checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL reset_mem_read got=%0h exp=0", mem_read); end
        checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL reset_mem_write got=%0h exp=0", mem_write); end
        checks++; if (mem_addr !== '0) begin failures++; $display("FAIL reset_mem_addr got=%0h exp=0", mem_addr); end
        checks++; if (mem_wdata !== '0) begin failures++; $display("FAIL reset_mem_wdata got=%0h exp=0", mem_wdata); end
        checks++; if ({req0_resp, req1_resp} !== 2'b00) begin failures++; $display("FAIL reset_resp got=%0b exp=00", {req0_resp, req1_resp}); end
        step();
        rst = 0;
        step();
        checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin failures++; $display("FAIL reset_idle got=%0b%0b exp=00", mem_read, mem_write); end
    endtask

    task automatic test_lone_read();
        logic [LW-1:0] pat = {(LW / 8){8'hA5}};
        req0_read = 1; req0_addr = 32'h0000_1040;
        step();
        for (int i = 1; i <= 4; i++) begin
            checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h0000_1040 || req0_resp !== 1'b0) begin
                failures++; $display("FAIL lone_busy cyc=%0d got rd=%0b addr=%0h resp=%0b exp rd=1 addr=1040 resp=0", i, mem_read, mem_addr, req0_resp);
            end
            step();
        end
        mem_resp = 1; mem_rdata = pat;
        #1;
        checks++; if (req0_resp !== 1'b1 || req1_resp !== 1'b0) begin failures++; $display("FAIL lone_resp got=%0b%0b exp=10", req0_resp, req1_resp); end
        checks++; if (req0_rdata !== pat) begin failures++; $display("FAIL lone_rdata got=%0h exp=%0h", req0_rdata, pat); end
        step();
        mem_resp = 0; req0_read = 0;
        #1;
        checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL lone_drop got=%0b exp=0", mem_read); end
        step();
    endtask

    task automatic test_tie();
        int w;
        logic got;
        do_reset();
        req0_read = 1; req0_addr = 32'h100;
        req1_read = 1; req1_addr = 32'h200;
        for (int n = 0; n < 4; n++) begin
            w = 0;
            while (mem_read !== 1'b1 && w < 6) begin step(); w++; end
            checks++; if (w >= 6) begin failures++; $display("FAIL tie_timeout n=%0d got=no_grant exp=grant", n); end
            got = (mem_addr == 32'h200);
            checks++; if (got !== (n % 2 == 1)) begin failures++; $display("FAIL tie_order n=%0d got=%0d exp=%0d", n, got, n % 2); end
            mem_resp = 1;
            #1;
            checks++; if (req0_resp !== (n % 2 == 0) || req1_resp !== (n % 2 == 1)) begin
                failures++; $display("FAIL tie_resp n=%0d got=%0b%0b exp_owner=%0d", n, req0_resp, req1_resp, n % 2);
            end
            step();
            mem_resp = 0;
        end
        idle_all();
        step();
        step();
    endtask

    task automatic test_affinity();
        logic [LW-1:0] wd = rand_line();
        do_reset();
        req1_write = 1; req1_addr = 32'h8000_0200; req1_wdata = wd;
        step();
        checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wdata !== wd) begin
            failures++; $display("FAIL aff_wb got wr=%0b rd=%0b wdata=%0h exp wr=1 rd=0 wdata=%0h", mem_write, mem_read, mem_wdata, wd);
        end
        req0_read = 1; req0_addr = 32'h0;
        step();
        mem_resp = 1;
        #1;
        checks++; if (req1_resp !== 1'b1 || req0_resp !== 1'b0) begin failures++; $display("FAIL aff_wb_resp got=%0b%0b exp=01", req0_resp, req1_resp); end
        step();
        mem_resp = 0; req1_write = 0; req1_read = 1;
        step();
        checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h8000_0200) begin
            failures++; $display("FAIL aff_refill got rd=%0b addr=%0h exp rd=1 addr=80000200", mem_read, mem_addr);
        end
        mem_resp = 1;
        #1;
        checks++; if (req1_resp !== 1'b1 || req0_resp !== 1'b0) begin failures++; $display("FAIL aff_refill_resp got=%0b%0b exp=01", req0_resp, req1_resp); end
        step();
        mem_resp = 0; req1_read = 0;
        step();
        checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h0) begin
            failures++; $display("FAIL aff_icache_next got rd=%0b addr=%0h exp rd=1 addr=0", mem_read, mem_addr);
        end
        mem_resp = 1;
        #1;
        checks++; if (req0_resp !== 1'b1 || req1_resp !== 1'b0) begin failures++; $display("FAIL aff_icache_resp got=%0b%0b exp=10", req0_resp, req1_resp); end
        step();
        idle_all();
        step();
    endtask

    task automatic test_stray();
        mem_resp = 1;
        #1;
        checks++; if ({req0_resp, req1_resp, mem_read, mem_write} !== 4'b0) begin
            failures++; $display("FAIL stray_resp got=%0b%0b%0b%0b exp=0000", req0_resp, req1_resp, mem_read, mem_write);
        end
        step();
        mem_resp = 0;
        #1;
        checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin failures++; $display("FAIL stray_state got=%0b%0b exp=00", mem_read, mem_write); end
        req0_read = 1; req0_addr = 32'h0000_2000;
        step();
        checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h0000_2000) begin
            failures++; $display("FAIL stray_next got rd=%0b addr=%0h exp rd=1 addr=2000", mem_read, mem_addr);
        end
        mem_resp = 1;
        step();
        idle_all();
        step();
    endtask

    task automatic test_reset_mid();
        req1_read = 1; req1_addr = 32'h300;
        step();
        checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h300) begin failures++; $display("FAIL rmid_busy got rd=%0b addr=%0h exp rd=1 addr=300", mem_read, mem_addr); end
        rst = 1; req1_read = 0;
        step();
        rst = 0;
        #1;
        checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL rmid_abort got=%0b exp=0", mem_read); end
        mem_resp = 1;
        #1;
        checks++; if (req1_resp !== 1'b0 || req0_resp !== 1'b0) begin failures++; $display("FAIL rmid_late_resp got=%0b%0b exp=00", req0_resp, req1_resp); end
        step();
        mem_resp = 0;
        req0_read = 1; req0_addr = 32'h100; req1_read = 1; req1_addr = 32'h300;
        step();
        checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h100) begin failures++; $display("FAIL rmid_tie got rd=%0b addr=%0h exp rd=1 addr=100", mem_read, mem_addr); end
        mem_resp = 1;
        step();
        idle_all();
        step();
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a;
        int lat;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            req1_read = 1; req1_addr = a;
            #1;
            checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL b2b_gap i=%0d got=%0b exp=0", i, mem_read); end
            step();
            lat = $urandom_range(1, 4);
            for (int j = 0; j < lat; j++) begin
                checks++; if (mem_read !== 1'b1 || mem_addr !== a || req1_resp !== 1'b0) begin
                    failures++; $display("FAIL b2b_busy i=%0d j=%0d got rd=%0b addr=%0h resp=%0b exp rd=1 addr=%0h resp=0", i, j, mem_read, mem_addr, req1_resp, a);
                end
                step();
            end
            mem_resp = 1;
            #1;
            checks++; if (req1_resp !== 1'b1 || req0_resp !== 1'b0) begin failures++; $display("FAIL b2b_resp i=%0d got=%0b%0b exp=01", i, req0_resp, req1_resp); end
            step();
            mem_resp = 0;
        end
        req1_read = 0;
        #1;
        checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL b2b_end got=%0b exp=0", mem_read); end
        step();
        checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL b2b_extra_grant got=%0b exp=0", mem_read); end
    endtask

    // Reference: whole-transaction view; who owns the port, what op/line it carries, who gets the next grant.
    task automatic test_random();
        int owner = -1, last = 1, aff = -1, g, code;
        logic mw = 0;
        logic [AW-1:0] ma = '0;
        logic [LW-1:0] md = '0;
        logic pr[2], pw[2], done[2];
        logic [AW-1:0] pa[2];
        logic [LW-1:0] pd[2];
        logic rq[2];
        logic e0, e1;
        do_reset();
        for (int k = 0; k < 2; k++) begin pr[k] = 0; pw[k] = 0; done[k] = 0; pa[k] = '0; pd[k] = '0; end
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (done[k]) begin
                    pr[k] = 0; pw[k] = 0; done[k] = 0;
                end else if (!pr[k] && !pw[k] && $urandom_range(0, 2) == 0) begin
                    code = $urandom_range(0, 4);
                    pr[k] = code < 2 || code == 4;
                    pw[k] = code >= 2;
                    pa[k] = $urandom;
                    pd[k] = rand_line();
                end
            end
            req0_read = pr[0]; req0_write = pw[0]; req0_addr = pa[0]; req0_wdata = pd[0];
            req1_read = pr[1]; req1_write = pw[1]; req1_addr = pa[1]; req1_wdata = pd[1];
            mem_resp = owner >= 0 ? $urandom_range(0, 2) == 0 : $urandom_range(0, 7) == 0;
            mem_rdata = rand_line();
            #1;
            e0 = owner == 0 && mem_resp;
            e1 = owner == 1 && mem_resp;
            checks++; if (mem_read !== (owner >= 0 && !mw) || mem_write !== (owner >= 0 && mw)) begin
                failures++; $display("FAIL rnd_op c=%0d got rd=%0b wr=%0b exp owner=%0d write=%0b", c, mem_read, mem_write, owner, mw);
            end
            checks++; if (mem_addr !== ma || mem_wdata !== md) begin
                failures++; $display("FAIL rnd_line c=%0d got addr=%0h exp addr=%0h", c, mem_addr, ma);
            end
            checks++; if (req0_resp !== e0 || req1_resp !== e1) begin
                failures++; $display("FAIL rnd_resp c=%0d got=%0b%0b exp=%0b%0b", c, req0_resp, req1_resp, e0, e1);
            end
            if (e0 || e1) begin
                checks++; if ((e0 ? req0_rdata : req1_rdata) !== mem_rdata) begin failures++; $display("FAIL rnd_rdata c=%0d got=%0h exp=%0h", c, e0 ? req0_rdata : req1_rdata, mem_rdata); end
            end
            done[0] = e0;
            done[1] = e1;
            if (owner < 0) begin
                rq[0] = pr[0] | pw[0];
                rq[1] = pr[1] | pw[1];
                if (rq[0] || rq[1]) begin
                    g = (aff >= 0 && rq[aff]) ? aff : (rq[0] && rq[1]) ? 1 - last : (rq[1] ? 1 : 0);
                    owner = g; last = g; mw = pw[g]; ma = pa[g]; md = pd[g];
                end
                aff = -1;
            end else if (mem_resp) begin
                if (mw) aff = owner;
                owner = -1;
            end
            step();
        end
        idle_all();
        step();
    endtask

    initial begin
        test_reset();
        test_lone_read();
        test_tie();
        test_affinity();
        test_stray();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
